chacha_sequencer: RTL and testbench
===================================

# chacha_sequencer

Control FSM that drives the four ChaCha quarter-round column slices through a complete block computation. A single start initiates the sequence:
- clear the working state to the loaded initial values;
- run the configured number of column/diagonal rounds, including the inter-round row rotations over the shift ring;
- add the initial values back in;
- hold the result readable until the host acknowledges, then bump the block counter.

The block sits between the host interface and the slice array, and is the only source of the slices' calc/step/shift/add_back/clear/inc_ctr controls.

## Interface

Parameters:
- DOUBLE_ROUNDS, default 10: number of column+diagonal round pairs (10 gives ChaCha20). Legal range is 1..16.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin block computation; sampled only in IDLE
- read_done  input  1  host has finished reading the output block; sampled only in DONE
- write_in  input  1  host byte-write request
- write_out  output  1  gated write to slices: write_in & (state==IDLE)
- busy  output  1  high in every state except IDLE
- done  output  1  high throughout DONE
- clear  output  1  slice clear strobe
- calc  output  1  slice calc strobe
- shift  output  1  slice row-shift strobe
- add_back  output  1  slice add-back strobe
- inc_ctr  output  1  slice counter-increment strobe
- step  output  2  step/row select to the slices
- round  output  5  index of the current round, 0..2*DOUBLE_ROUNDS-1

## Operation

States: IDLE, CLEAR, CALC, SHIFT, ADD, DONE, INC.

- **IDLE**
  - All strobes are 0 and step=0.
  - start=1 → CLEAR.
- **CLEAR**
  - clear=1 for 1 cycle.
  - Resets round=0 and the sub-counter to 0.
  - → CALC.
- **CALC**
  - calc=1 for 4 cycles, with step=0,1,2,3 in that order.
  - → SHIFT.
- **SHIFT**
  - shift=1 for 6 cycles; sub-counter k=0..5.
  - Even round (column → diagonal): step = 1 (k=0), 2 (k=1,2), 3 (k=3..5). This rotates b by 1, c by 2 and d by 3.
  - Odd round (diagonal → column): step = 1 (k=0..2), 2 (k=3,4), 3 (k=5). This restores the column layout.
  - After k=5:
    - if round == 2*DOUBLE_ROUNDS-1 → ADD;
    - otherwise round increments → CALC.
- **ADD**
  - add_back=1 for 1 cycle.
  - → DONE.
- **DONE**
  - done=1; the result stays stable.
  - read_done=1 → INC.
- **INC**
  - inc_ctr=1 for 1 cycle.
  - → IDLE.

Global rules:
- At most one of clear/calc/shift/add_back/inc_ctr is high in any cycle.
- step=0 whenever calc=0 and shift=0.
- start outside IDLE and read_done outside DONE are ignored, with no queuing.
- write_in while busy is dropped: write_out=0.
- round is an unsigned 5-bit value that never exceeds 2*DOUBLE_ROUNDS-1, so there is no wrap-around. It holds its last value in ADD/DONE/INC and is reset to 0 in CLEAR.

## Timing

- All outputs are registered or decoded from registered state; there is no combinational path from start or read_done to the strobes.
- write_out is combinational from write_in.
- Reset (rst high at a clock edge), from any state including mid-round:
  - next state IDLE;
  - every strobe 0, busy=0, done=0, step=0, round=0, sub-counter 0.
- The slices are not cleaned up by reset; the next start re-clears them.
- Latency, with start sampled high at edge N:
  - clear is high in cycle N+1;
  - the first calc is in N+2;
  - each round takes 10 cycles (4 calc + 6 shift);
  - add_back is in cycle N+2+20*DOUBLE_ROUNDS;
  - done rises in the following cycle (N+203 for the default).
- read_done sampled high in DONE gives inc_ctr in the next cycle, and IDLE (busy=0) the cycle after that.
- Back-to-back blocks: start may be asserted in the first IDLE cycle after INC.

## Test plan

- **Reset values.** Hold rst for 3 cycles, including once mid-CALC of round 7.
  - Required: all strobes 0, step=0, round=0, busy=0, done=0 on the cycle after each reset edge.
- **Full default sequence.** Pulse start at cycle 0.
  - clear is high at cycle 1 only.
  - Exactly 80 calc cycles and 120 shift cycles occur.
  - add_back is high at cycle 202 only; done rises at cycle 203.
  - Per-round shift step counts: even rounds 1/2/3, odd rounds 3/2/1.
- **Step order.** In every round: step sequence 0,1,2,3 under calc.
  - SHIFT of round 0 = 1,2,2,3,3,3.
  - SHIFT of round 1 = 1,1,1,2,2,3.
  - round output steps 0→19.
- **Ignored inputs.**
  - start pulsed at cycles 50 and 203: no restart.
  - read_done pulsed at cycle 100: no effect.
  - write_in high during busy: write_out=0. write_in high in IDLE: write_out=1.
- **Acknowledge and counter bump.** In DONE, hold 5 cycles, then pulse read_done.
  - inc_ctr is high for exactly 1 cycle.
  - busy falls the cycle after that.
  - A start in that first IDLE cycle restarts with clear one cycle later.
- **Parameter corner.** With DOUBLE_ROUNDS=1: add_back occurs at cycle 22 after start at cycle 0, and round never exceeds 1.

Source files
------------

// File: rtl/chacha_sequencer_if.sv
// Host/slice control bundle for the ChaCha block sequencer.
// slave = sequencer side, master = host/bench side.
interface chacha_sequencer_if;
  logic       start;
  logic       read_done;
  logic       write_in;
  logic       write_out;
  logic       busy;
  logic       done;
  logic       clear;
  logic       calc;
  logic       shift;
  logic       add_back;
  logic       inc_ctr;
  logic [1:0] step;
  logic [4:0] round;

  modport slave (
    input  start, read_done, write_in,
    output write_out, busy, done, clear, calc, shift, add_back, inc_ctr, step, round
  );

  modport master (
    output start, read_done, write_in,
    input  write_out, busy, done, clear, calc, shift, add_back, inc_ctr, step, round
  );
endinterface

// File: rtl/chacha_sequencer.sv
// Control FSM sequencing the ChaCha quarter-round slices through one block:
// clear, 2*DOUBLE_ROUNDS rounds of calc + row shift, add-back, hold, counter bump.
module chacha_sequencer #(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input logic              clk,
  input logic              rst,
  chacha_sequencer_if.slave bus
);
  localparam int unsigned ROUND_W    = 5;
  localparam int unsigned SUB_W      = 3;
  localparam int unsigned STEP_W     = 2;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(2 * DOUBLE_ROUNDS - 1);
  localparam logic [SUB_W-1:0]   LAST_CALC  = SUB_W'(3);
  localparam logic [SUB_W-1:0]   LAST_SHIFT = SUB_W'(5);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CALC, S_SHIFT, S_ADD, S_DONE, S_INC
  } state_t;

  state_t           state;
  logic [SUB_W-1:0] sub;

  // Row rotation select: even rounds move columns to diagonals, odd rounds undo it.
  function automatic logic [STEP_W-1:0] shift_step(input logic odd, input logic [SUB_W-1:0] k);
    if (!odd) shift_step = (k == SUB_W'(0)) ? STEP_W'(1) : (k < SUB_W'(3)) ? STEP_W'(2) : STEP_W'(3);
    else      shift_step = (k < SUB_W'(3))  ? STEP_W'(1) : (k < SUB_W'(5)) ? STEP_W'(2) : STEP_W'(3);
  endfunction

  assign bus.write_out = bus.write_in & (state == S_IDLE);

  // Outputs are registered alongside the state: each branch sets the values for the state entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sub          <= '0;
      bus.round    <= '0;
      bus.step     <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.clear    <= 1'b0;
      bus.calc     <= 1'b0;
      bus.shift    <= 1'b0;
      bus.add_back <= 1'b0;
      bus.inc_ctr  <= 1'b0;
    end else begin
      bus.clear    <= 1'b0;
      bus.calc     <= 1'b0;
      bus.shift    <= 1'b0;
      bus.add_back <= 1'b0;
      bus.inc_ctr  <= 1'b0;
      bus.step     <= '0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b1;
      case (state)
        S_IDLE: begin
          bus.busy <= bus.start;
          if (bus.start) begin
            state     <= S_CLEAR;
            bus.clear <= 1'b1;
            bus.round <= '0;
            sub       <= '0;
          end
        end
        S_CLEAR: begin
          state     <= S_CALC;
          bus.round <= '0;
          sub       <= '0;
          bus.calc  <= 1'b1;
        end
        S_CALC: begin
          if (sub == LAST_CALC) begin
            state     <= S_SHIFT;
            sub       <= '0;
            bus.shift <= 1'b1;
            bus.step  <= shift_step(bus.round[0], SUB_W'(0));
          end else begin
            sub      <= sub + SUB_W'(1);
            bus.calc <= 1'b1;
            bus.step <= STEP_W'(sub + SUB_W'(1));
          end
        end
        S_SHIFT: begin
          if (sub == LAST_SHIFT) begin
            sub <= '0;
            if (bus.round == LAST_ROUND) begin
              state        <= S_ADD;
              bus.add_back <= 1'b1;
            end else begin
              state     <= S_CALC;
              bus.round <= bus.round + ROUND_W'(1);
              bus.calc  <= 1'b1;
            end
          end else begin
            sub       <= sub + SUB_W'(1);
            bus.shift <= 1'b1;
            bus.step  <= shift_step(bus.round[0], sub + SUB_W'(1));
          end
        end
        S_ADD: begin
          state    <= S_DONE;
          bus.done <= 1'b1;
        end
        S_DONE: begin
          if (bus.read_done) begin
            state       <= S_INC;
            bus.inc_ctr <= 1'b1;
          end else begin
            bus.done <= 1'b1;
          end
        end
        S_INC: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_sequencer.sv
// Directed bench for chacha_sequencer: default (ChaCha20) instance plus a DOUBLE_ROUNDS=1 instance.
module tb_chacha_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  chacha_sequencer_if bus1 ();
  chacha_sequencer_if bus2 ();

  chacha_sequencer #(.DOUBLE_ROUNDS(10)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  chacha_sequencer #(.DOUBLE_ROUNDS(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Observation vector: {clear,calc,shift,add_back,inc_ctr,busy,done,step[1:0],round[4:0]}
  logic [13:0] obs1, obs2;
  assign obs1 = {bus1.clear, bus1.calc, bus1.shift, bus1.add_back, bus1.inc_ctr,
                 bus1.busy, bus1.done, bus1.step, bus1.round};
  assign obs2 = {bus2.clear, bus2.calc, bus2.shift, bus2.add_back, bus2.inc_ctr,
                 bus2.busy, bus2.done, bus2.step, bus2.round};

  logic [1:0] even_tab [6] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] odd_tab  [6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};

  // Expected outputs at cycle c of a block started at cycle 0 from a freshly reset IDLE, no ack.
  function automatic logic [13:0] exp_vec(input int c, input int dr);
    logic cl, ca, sh, ad, bs, dn;
    logic [1:0] st;
    logic [4:0] rd;
    int r, p;
    cl = 0; ca = 0; sh = 0; ad = 0; bs = 0; dn = 0; st = 2'd0; rd = 5'd0;
    if (c == 1) begin
      cl = 1; bs = 1;
    end else if (c >= 2 && c <= 1 + 20 * dr) begin
      r = (c - 2) / 10;
      p = (c - 2) % 10;
      bs = 1;
      rd = 5'(r);
      if (p < 4) begin
        ca = 1; st = 2'(p);
      end else begin
        sh = 1;
        st = (r % 2 == 1) ? odd_tab[p - 4] : even_tab[p - 4];
      end
    end else if (c == 2 + 20 * dr) begin
      ad = 1; bs = 1; rd = 5'(2 * dr - 1);
    end else if (c > 2 + 20 * dr) begin
      dn = 1; bs = 1; rd = 5'(2 * dr - 1);
    end
    return {cl, ca, sh, ad, 1'b0, bs, dn, st, rd};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    int n_calc, n_shift, add_cyc, clear_first, done_rise, max_round;
    rst = 1'b1;
    bus1.start = 0; bus1.read_done = 0; bus1.write_in = 0;
    bus2.start = 0; bus2.read_done = 0; bus2.write_in = 0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_vec1", 32'(obs1), 32'd0);
    check("reset_vec2", 32'(obs2), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full default block with ignored start/read_done pulses and a busy write.
    n_calc = 0; n_shift = 0; add_cyc = -1; clear_first = -1; done_rise = -1;
    for (int c = 0; c <= 208; c++) begin
      bus1.start     = (c == 0 || c == 50 || c == 203);
      bus1.read_done = (c == 100 || c == 208);
      bus1.write_in  = (c == 30);
      #1;
      check($sformatf("vec1_c%0d", c), 32'(obs1), 32'(exp_vec(c, 10)));
      if (c == 30) check("write_out_busy", 32'(bus1.write_out), 32'd0);
      if (bus1.calc) n_calc++;
      if (bus1.shift) n_shift++;
      if (bus1.add_back && add_cyc < 0) add_cyc = c;
      if (bus1.clear && clear_first < 0) clear_first = c;
      if (bus1.done && done_rise < 0) done_rise = c;
      @(negedge clk);
    end
    check("calc_count", 32'(n_calc), 32'd80);
    check("shift_count", 32'(n_shift), 32'd120);
    check("add_back_cycle", 32'(add_cyc), 32'd202);
    check("clear_cycle", 32'(clear_first), 32'd1);
    check("done_rise", 32'(done_rise), 32'd203);

    // Cycle 209: counter bump after ack.
    bus1.start = 0; bus1.read_done = 0; bus1.write_in = 0;
    #1;
    check("inc_ctr_209", 32'({bus1.inc_ctr, bus1.busy, bus1.done}), 32'b110);
    check("round_hold_209", 32'(bus1.round), 32'd19);
    @(negedge clk);

    // Cycle 210: first IDLE cycle, write passes, restart.
    bus1.write_in = 1; bus1.start = 1;
    #1;
    check("idle_210", 32'({bus1.inc_ctr, bus1.busy, bus1.done, bus1.clear}), 32'b0000);
    check("write_out_idle", 32'(bus1.write_out), 32'd1);
    @(negedge clk);
    bus1.write_in = 0; bus1.start = 0;
    #1;
    check("restart_clear", 32'({bus1.clear, bus1.busy, bus1.round}), 32'({1'b1, 1'b1, 5'd0}));

    // Advance into round 7 CALC (relative cycle 73) then reset mid-round.
    repeat (72) @(negedge clk);
    #1;
    check("mid_round7", 32'({bus1.calc, bus1.step, bus1.round}), 32'({1'b1, 2'd1, 5'd7}));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("mid_reset_%0d", i), 32'(obs1), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_idle", 32'(obs1), 32'd0);
    @(negedge clk);

    // DOUBLE_ROUNDS=1 corner.
    add_cyc = -1; max_round = 0;
    for (int c = 0; c <= 25; c++) begin
      bus2.start = (c == 0);
      #1;
      check($sformatf("vec2_c%0d", c), 32'(obs2), 32'(exp_vec(c, 1)));
      if (bus2.add_back && add_cyc < 0) add_cyc = c;
      if (int'(bus2.round) > max_round) max_round = int'(bus2.round);
      @(negedge clk);
    end
    check("dr1_add_back_cycle", 32'(add_cyc), 32'd22);
    check("dr1_max_round", 32'(max_round), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
